// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: receiver state encoding, parity
//                mode constants (common to RX and TX) and bit-period helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5,
        DONE   = 3'd6
    } uart_rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clock cycles per serial bit, truncated; clk_freq is given in MHz.
    function automatic int cycles_per_bit(input int clk_freq, input int bit_rate);
        longint l_cyc;
        l_cyc = (longint'(clk_freq) * 64'sd1_000_000) / longint'(bit_rate);
        return int'(l_cyc);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sync
//  Description : Two-flop synchroniser for the asynchronous serial input plus
//                falling-edge detection on the synchronised line. All flops
//                reset to 1 (line idle) so reset release never looks like a
//                start bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rx,
    output logic o_rx,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Metastability chain plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rx   = r_sync;
    assign o_fall = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_to_axis.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_to_axis
//  Description : UART receiver presenting received words on an AXI-Stream
//                master port through a single-entry output buffer.
//                Optional macro UART_RX_ERR_TUSER_EN: errored words are
//                delivered with m_axis_tuser = {frame_err, parity_err};
//                without it, errored words are discarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_to_axis
    import uart_pkg::*;
#(
    parameter int CLK_FREQ      = 100,
    parameter int BIT_RATE      = 115200,
    parameter int BIT_PER_WORD  = 8,
    parameter int PARITY_BIT    = 0,
    parameter int STOP_BITS_NUM = 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    rx,
    output logic [BIT_PER_WORD-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
`ifdef UART_RX_ERR_TUSER_EN
    output logic [1:0]              m_axis_tuser,
`endif
    output logic                    parity_err,
    output logic                    frame_err,
    output logic                    overrun_err,
    output logic                    busy
);

    localparam int CPB  = cycles_per_bit(CLK_FREQ, BIT_RATE);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB + 1);

    localparam logic [CW-1:0] c_cpb_m1   = CW'(CPB - 1);
    localparam logic [CW-1:0] c_half_m1  = CW'(HALF - 1);
    localparam logic [3:0]    c_last_bit = 4'(BIT_PER_WORD - 1);
    localparam logic          c_par_odd  = (PARITY_BIT == PAR_ODD);

    uart_rx_state_t r_state;
    uart_rx_state_t w_state_next;

    logic                    w_rx;
    logic                    w_fall;
    logic                    w_tick;
    logic [CW-1:0]           r_cnt;
    logic [3:0]              r_bit_cnt;
    logic [BIT_PER_WORD-1:0] r_shift;
    logic                    r_par_err;
    logic                    r_frm_err;

    uart_rx_sync u_sync (
        .clk    (aclk),
        .rst_n  (aresetn),
        .i_rx   (rx),
        .o_rx   (w_rx),
        .o_fall (w_fall)
    );

    // START samples after half a bit; every later sample is one full bit on.
    assign w_tick = (r_state == START) ? (r_cnt == c_half_m1) : (r_cnt == c_cpb_m1);
    assign busy   = (r_state != IDLE);

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: advance on each bit-period tick.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:   if (w_fall) w_state_next = START;
            START:  if (w_tick) w_state_next = w_rx ? IDLE : DATA;
            DATA:   if (w_tick && (r_bit_cnt == c_last_bit))
                        w_state_next = (PARITY_BIT != PAR_NONE) ? PARITY : STOP1;
            PARITY: if (w_tick) w_state_next = STOP1;
            STOP1:  if (w_tick) w_state_next = (STOP_BITS_NUM == 2) ? STOP2 : DONE;
            STOP2:  if (w_tick) w_state_next = DONE;
            DONE:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Bit timing, data shifting and per-frame error flags.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            if ((r_state == IDLE) || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (r_state == IDLE) begin
                r_bit_cnt <= '0;
                r_par_err <= 1'b0;
                r_frm_err <= 1'b0;
            end else if (w_tick) begin
                case (r_state)
                    DATA: begin
                        // LSB arrives first, so shift in from the top.
                        r_shift   <= {w_rx, r_shift[BIT_PER_WORD-1:1]};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                    PARITY: r_par_err <= ((^{r_shift, w_rx}) != c_par_odd);
                    STOP1, STOP2: if (!w_rx) r_frm_err <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Output buffer: commit in DONE, release on handshake, one-cycle error pulses.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
`ifdef UART_RX_ERR_TUSER_EN
            m_axis_tuser  <= 2'b00;
`endif
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
            overrun_err   <= 1'b0;
        end else begin
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;

            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            if (r_state == DONE) begin
                parity_err <= r_par_err;
                frame_err  <= r_frm_err;
`ifdef UART_RX_ERR_TUSER_EN
                if (!m_axis_tvalid || m_axis_tready) begin
                    m_axis_tdata  <= r_shift;
                    m_axis_tuser  <= {r_frm_err, r_par_err};
                    m_axis_tvalid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
`else
                if (!(r_par_err || r_frm_err)) begin
                    if (!m_axis_tvalid || m_axis_tready) begin
                        m_axis_tdata  <= r_shift;
                        m_axis_tvalid <= 1'b1;
                    end else begin
                        overrun_err <= 1'b1;
                    end
                end
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_to_axis.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_to_axis
//  Description : Self-checking bench for uart_rx_to_axis. A frame-level model
//                predicts delivered words and error pulse counts; one monitor
//                process compares the stream output every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_to_axis;

    localparam int CLK_FREQ = 100;
    localparam int BIT_RATE = 1_000_000;
    localparam int W        = 8;
    localparam int PAR      = 2;
    localparam int STOPS    = 1;
    localparam int CPB      = CLK_FREQ * 1_000_000 / BIT_RATE;

    typedef struct {
        logic [W-1:0] d;
        logic [1:0]   u;
    } exp_t;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic         rx = 1'b1;
    logic         m_axis_tready = 1'b0;
    logic [W-1:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         parity_err;
    logic         frame_err;
    logic         overrun_err;
    logic         busy;
`ifdef UART_RX_ERR_TUSER_EN
    logic [1:0]   m_axis_tuser;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t exp_q[$];
    int exp_perr = 0, exp_ferr = 0, exp_ovr = 0;
    int obs_perr = 0, obs_ferr = 0, obs_ovr = 0;
    bit stall = 0;
    bit model_full = 0;
    int ready_mode = 1;
    int rise_cyc = 0;
    int stop_mid = 0;
    bit glitch_mon = 0;
    int busy_cnt = 0;
    logic [W-1:0] last_data = '0;
    bit prev_v = 0, prev_r = 0;
    logic [W-1:0] prev_d = '0;

    uart_rx_to_axis #(
        .CLK_FREQ      (CLK_FREQ),
        .BIT_RATE      (BIT_RATE),
        .BIT_PER_WORD  (W),
        .PARITY_BIT    (PAR),
        .STOP_BITS_NUM (STOPS)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .rx            (rx),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
`ifdef UART_RX_ERR_TUSER_EN
        .m_axis_tuser  (m_axis_tuser),
`endif
        .parity_err    (parity_err),
        .frame_err     (frame_err),
        .overrun_err   (overrun_err),
        .busy          (busy)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    // Downstream ready: held low, held high, or random per cycle.
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            case (ready_mode)
                0:       m_axis_tready = 1'b0;
                1:       m_axis_tready = 1'b1;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Compare process: stream handshakes against the model queue, hold rules,
    // and error pulse counting.
    always @(negedge aclk) begin
        exp_t e;
        if (!aresetn) begin
            prev_v = 0;
        end else begin
            if (prev_v && !prev_r) begin
                check(m_axis_tvalid === 1'b1, "tvalid_hold", longint'(m_axis_tvalid), 1);
                check(m_axis_tdata === prev_d, "tdata_hold", longint'(m_axis_tdata), longint'(prev_d));
            end
            if (m_axis_tvalid && !prev_v) rise_cyc = cyc;
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_word", longint'(m_axis_tdata), 0);
                end else begin
                    e = exp_q.pop_front();
                    check(m_axis_tdata === e.d, "tdata", longint'(m_axis_tdata), longint'(e.d));
`ifdef UART_RX_ERR_TUSER_EN
                    check(m_axis_tuser === e.u, "tuser", longint'(m_axis_tuser), longint'(e.u));
`endif
                end
                last_data = m_axis_tdata;
            end
            obs_perr += int'(parity_err);
            obs_ferr += int'(frame_err);
            obs_ovr  += int'(overrun_err);
            if (glitch_mon && busy) busy_cnt++;
            prev_v = m_axis_tvalid;
            prev_r = m_axis_tready;
            prev_d = m_axis_tdata;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge aclk);
    endtask

    // Model: a word is queued unless the single buffer is known to be full.
    task automatic model_accept(input exp_t e);
        if (stall && model_full) begin
            exp_ovr++;
        end else begin
            exp_q.push_back(e);
            if (stall) model_full = 1;
        end
    endtask

    task automatic send_frame(input logic [W-1:0] d, input bit flip_par, input bit stop_low);
        exp_t e;
        int   nb;
        e.d = d;
        e.u = {stop_low, flip_par};
        exp_perr += int'(flip_par);
        exp_ferr += int'(stop_low);
`ifdef UART_RX_ERR_TUSER_EN
        model_accept(e);
`else
        if (!(flip_par || stop_low)) model_accept(e);
`endif
        nb = 1 + W + ((PAR != 0) ? 1 : 0);
        @(negedge aclk);
        stop_mid = cyc + nb * CPB + CPB / 2;
        drive_bit(1'b0);
        for (int i = 0; i < W; i++) drive_bit(d[i]);
        if (PAR != 0) drive_bit(((PAR == 1) ? ~(^d) : (^d)) ^ flip_par);
        for (int s = 0; s < STOPS; s++) drive_bit(stop_low ? 1'b0 : 1'b1);
        rx = 1'b1;
    endtask

    task automatic check_counts(input string tag);
        check(obs_perr == exp_perr, {tag, "_parity_err_count"}, obs_perr, exp_perr);
        check(obs_ferr == exp_ferr, {tag, "_frame_err_count"}, obs_ferr, exp_ferr);
        check(obs_ovr == exp_ovr, {tag, "_overrun_err_count"}, obs_ovr, exp_ovr);
    endtask

    initial begin
        logic [W-1:0] d;
        bit fp, sl;

        ready_mode = 1;
        repeat (5) @(negedge aclk);
        check(m_axis_tvalid === 1'b0, "reset_tvalid", longint'(m_axis_tvalid), 0);
        check(m_axis_tdata === '0, "reset_tdata", longint'(m_axis_tdata), 0);
        check(busy === 1'b0, "reset_busy", longint'(busy), 0);
        check({parity_err, frame_err, overrun_err} === 3'b000, "reset_errs",
              longint'({parity_err, frame_err, overrun_err}), 0);
        aresetn = 1'b1;
        idle(10);

        // Single good word, timing of tvalid against the stop-bit middle.
        send_frame(8'hA5, 0, 0);
        idle(20);
        check((rise_cyc - stop_mid >= 2) && (rise_cyc - stop_mid <= 6), "tvalid_rise_delay",
              rise_cyc - stop_mid, 4);
        check(last_data === 8'hA5, "first_word", longint'(last_data), 8'hA5);
        check_counts("good");

        // Correct parity then flipped parity.
        send_frame(8'h3C, 0, 0);
        send_frame(8'h3C, 1, 0);
        idle(20);
        check_counts("parity");

        // Stop bit low.
        send_frame(8'h55, 0, 1);
        idle(CPB);
        check_counts("frame");

        // Short low glitch on an idle line.
        busy_cnt = 0;
        glitch_mon = 1;
        rx = 1'b0;
        idle(40);
        rx = 1'b1;
        idle(200);
        glitch_mon = 0;
        check((busy_cnt >= 49) && (busy_cnt <= 51), "glitch_busy_cycles", busy_cnt, CPB / 2);
        check_counts("glitch");

        // Overrun with downstream stalled.
        ready_mode = 0;
        idle(3);
        stall = 1;
        model_full = 0;
        send_frame(8'h11, 0, 0);
        send_frame(8'h22, 0, 0);
        idle(20);
        check(m_axis_tvalid === 1'b1, "stall_tvalid", longint'(m_axis_tvalid), 1);
        check(m_axis_tdata === 8'h11, "stall_tdata", longint'(m_axis_tdata), 8'h11);
        check_counts("overrun");
        stall = 0;
        model_full = 0;
        ready_mode = 1;
        idle(10);
        check(exp_q.size() == 0, "overrun_drain", exp_q.size(), 0);
        check(last_data === 8'h11, "overrun_kept_word", longint'(last_data), 8'h11);

        // Reset in the middle of a frame with a word pending.
        ready_mode = 0;
        idle(3);
        stall = 1;
        send_frame(8'h5A, 0, 0);
        idle(20);
        check(m_axis_tvalid === 1'b1, "pre_reset_tvalid", longint'(m_axis_tvalid), 1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        idle(CPB / 2);
        aresetn = 1'b0;
        #1;
        check(m_axis_tvalid === 1'b0, "reset_mid_tvalid", longint'(m_axis_tvalid), 0);
        check(busy === 1'b0, "reset_mid_busy", longint'(busy), 0);
        exp_q.delete();
        model_full = 0;
        stall = 0;
        ready_mode = 1;
        idle(3);
        rx = 1'b1;
        idle(3);
        aresetn = 1'b1;
        idle(10);
        send_frame(8'h0F, 0, 0);
        idle(20);
        check(last_data === 8'h0F, "after_reset_word", longint'(last_data), 8'h0F);
        check_counts("reset");

        // Randomised frames with occasional parity/stop faults.
        ready_mode = 2;
        repeat (20) begin
            d  = W'($urandom);
            fp = (PAR != 0) && ($urandom_range(0, 3) == 0);
            sl = ($urandom_range(0, 4) == 0);
            send_frame(d, fp, sl);
            idle(sl ? CPB : int'($urandom_range(2, 30)));
        end
        idle(50);
        check_counts("random");
        check(exp_q.size() == 0, "random_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
